// File: rtl/pkg_jogo.sv
// Shared encodings for the battleship game controller: FSM states, phase and
// result codes, mode requests and coordinate limits.
package pkg_jogo;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_POS  = 3'd1,
      S_ATK  = 3'd2,
      S_EVAL = 3'd3,
      S_END  = 3'd4
   } state_t;

   typedef enum logic [2:0] {
      RES_NONE    = 3'd0,
      RES_HIT     = 3'd1,
      RES_MISS    = 3'd2,
      RES_REPEAT  = 3'd3,
      RES_INVALID = 3'd4,
      RES_WIN     = 3'd5,
      RES_LOSE    = 3'd6
   } result_t;

   localparam logic [1:0] MODE_IDLE = 2'b00;
   localparam logic [1:0] MODE_POS  = 2'b01;
   localparam logic [1:0] MODE_ATK  = 2'b10;

   localparam logic [1:0] PH_IDLE = 2'b00;
   localparam logic [1:0] PH_POS  = 2'b01;
   localparam logic [1:0] PH_ATK  = 2'b10;
   localparam logic [1:0] PH_END  = 2'b11;

   localparam logic [2:0] ROW_MIN = 3'd1;
   localparam logic [2:0] ROW_MAX = 3'd7;
   localparam logic [2:0] COL_MIN = 3'd1;
   localparam logic [2:0] COL_MAX = 3'd5;

   localparam logic [5:0] CNT_SAT = 6'd63;

   function automatic logic [5:0] sat_inc(input logic [5:0] v);
      return (v == CNT_SAT) ? v : v + 6'd1;
   endfunction

endpackage

// File: rtl/modulo_debounce_botao.sv
// Synchronises and debounces the active-low confirmation button; emits a single
// one-cycle pulse per accepted press.
module modulo_debounce_botao #(
   parameter int DEB_CYCLES = 500000
) (
   input  logic clk,
   input  logic clr_n,
   input  logic btn_n,
   output logic pulse
);

   localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LOAD = CW'(DEB_CYCLES - 1);

   logic          sync_1;
   logic          sync_2;
   logic          level;
   logic [CW-1:0] cnt;

   // level is the accepted button state; it only flips after DEB_CYCLES
   // consecutive samples disagreeing with it, in either direction.
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         sync_1 <= 1'b1;
         sync_2 <= 1'b1;
         level  <= 1'b1;
         cnt    <= CNT_LOAD;
         pulse  <= 1'b0;
      end else begin
         sync_1 <= btn_n;
         sync_2 <= sync_1;
         pulse  <= 1'b0;
         if (sync_2 == level) begin
            cnt <= CNT_LOAD;
         end else if (cnt == '0) begin
            level <= sync_2;
            cnt   <= CNT_LOAD;
            pulse <= ~sync_2;
         end else begin
            cnt <= cnt - CW'(1);
         end
      end
   end

endmodule

// File: rtl/modulo_controle_partida.sv
// Battleship game sequencer: phase FSM, matrix strobes, shot evaluation and
// shot/hit counters driven by the debounced confirmation button.
//
// state  | meaning
// S_IDLE | no game; waiting for a position request
// S_POS  | preset loaded into position matrix; waiting for attack request
// S_ATK  | waiting for a shot confirmation
// S_EVAL | one cycle: classify shot at coord_q, update counters
// S_END  | game over (WIN/LOSE); holds until abort
module modulo_controle_partida
   import pkg_jogo::*;
#(
   parameter int DEB_CYCLES = 500000,
   parameter int MAX_SHOTS  = 15,
   parameter int SHIP_CELLS = 8
) (
   input  logic       clk,
   input  logic       clr_n,
   input  logic       button_confirmation,
   input  logic [1:0] mode,
   input  logic [5:0] coord,
   input  logic       ship_hit,
   input  logic       cell_attacked,
   output logic [5:0] coord_q,
   output logic       pos_load,
   output logic       pos_clr,
   output logic       at_wr,
   output logic       at_clr,
   output logic [1:0] phase,
   output logic [2:0] result,
   output logic [5:0] shots,
   output logic [5:0] hits
);

   localparam logic [5:0] SHIP_TC = 6'(SHIP_CELLS);
   localparam logic [5:0] SHOT_TC = 6'(MAX_SHOTS);

   logic       confirm;
   state_t     state, state_nx;
   result_t    result_q, result_nx;
   logic [5:0] coord_nx, shots_nx, hits_nx;
   logic       pos_load_nx, pos_clr_nx, at_wr_nx, at_clr_nx;
   logic       coord_ok;
   logic [2:0] row, col;

   modulo_debounce_botao #(
      .DEB_CYCLES(DEB_CYCLES)
   ) u_debounce (
      .clk  (clk),
      .clr_n(clr_n),
      .btn_n(button_confirmation),
      .pulse(confirm)
   );

   assign row      = coord_q[5:3];
   assign col      = coord_q[2:0];
   assign coord_ok = (row >= ROW_MIN) && (row <= ROW_MAX) &&
                     (col >= COL_MIN) && (col <= COL_MAX);

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         state    <= S_IDLE;
         coord_q  <= '0;
         shots    <= '0;
         hits     <= '0;
         result_q <= RES_NONE;
         pos_load <= 1'b0;
         pos_clr  <= 1'b0;
         at_wr    <= 1'b0;
         at_clr   <= 1'b0;
      end else begin
         state    <= state_nx;
         coord_q  <= coord_nx;
         shots    <= shots_nx;
         hits     <= hits_nx;
         result_q <= result_nx;
         pos_load <= pos_load_nx;
         pos_clr  <= pos_clr_nx;
         at_wr    <= at_wr_nx;
         at_clr   <= at_clr_nx;
      end
   end

   always_comb begin
      state_nx    = state;
      coord_nx    = coord_q;
      shots_nx    = shots;
      hits_nx     = hits;
      result_nx   = result_q;
      pos_load_nx = 1'b0;
      pos_clr_nx  = 1'b0;
      at_wr_nx    = 1'b0;
      at_clr_nx   = 1'b0;

      if (state == S_EVAL) begin
         state_nx = S_ATK;
         if (!coord_ok) begin
            result_nx = RES_INVALID;
         end else if (cell_attacked) begin
            result_nx = RES_REPEAT;
         end else begin
            at_wr_nx  = 1'b1;
            shots_nx  = sat_inc(shots);
            hits_nx   = ship_hit ? sat_inc(hits) : hits;
            result_nx = ship_hit ? RES_HIT : RES_MISS;
            // WIN is tested first so a winning last shot is not reported as LOSE.
            if (hits_nx == SHIP_TC) begin
               result_nx = RES_WIN;
               state_nx  = S_END;
            end else if (shots_nx == SHOT_TC) begin
               result_nx = RES_LOSE;
               state_nx  = S_END;
            end
         end
      end else if (confirm) begin
         if (mode == MODE_IDLE) begin
            state_nx   = S_IDLE;
            shots_nx   = '0;
            hits_nx    = '0;
            result_nx  = RES_NONE;
            pos_clr_nx = 1'b1;
            at_clr_nx  = 1'b1;
         end else begin
            case (state)
               S_IDLE: if (mode == MODE_POS) begin
                  pos_load_nx = 1'b1;
                  state_nx    = S_POS;
               end
               S_POS: if (mode == MODE_ATK) begin
                  result_nx = RES_NONE;
                  state_nx  = S_ATK;
               end
               S_ATK: if (mode == MODE_POS || mode == MODE_ATK) begin
                  coord_nx = coord;
                  state_nx = S_EVAL;
               end
               default: ;
            endcase
         end
      end
   end

   always_comb begin
      phase = PH_IDLE;
      case (state)
         S_POS:          phase = PH_POS;
         S_ATK, S_EVAL:  phase = PH_ATK;
         S_END:          phase = PH_END;
         default:        phase = PH_IDLE;
      endcase
   end

   assign result = result_q;

endmodule
